// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and a counter-width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = x - y - bi, with borrow-out bo.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first, using a
// single full-subtractor cell and a registered running borrow.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, next_state;

  logic [WIDTH-1:0] sa, sb, diff_reg, diff_next;
  logic [CW-1:0]    count;
  logic             borrow, bout_reg;
  logic             d, nb, last_bit;

  fs_cell u_cell (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (borrow),
    .d  (d),
    .bo (nb)
  );

  assign last_bit = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // New difference bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  always_comb begin
    diff_next            = diff_reg >> 1;
    diff_next[WIDTH-1]   = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      diff_reg <= '0;
      count    <= '0;
      borrow   <= 1'b0;
      bout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            count  <= '0;
          end
        end
        RUN: begin
          sa       <= sa >> 1;
          sb       <= sb >> 1;
          borrow   <= nb;
          count    <= count + 1'b1;
          diff_reg <= diff_next;
          if (last_bit) bout_reg <= nb;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign diff = diff_reg;
  assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 1, 8 and 16 against an
// arithmetic reference model of a - b - bin.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start1 = 1'b0, bin1 = 1'b0, busy1, done1, bout1;
  logic [0:0]  a1 = '0, b1 = '0, diff1;
  logic        start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
  logic [7:0]  a8 = '0, b8 = '0, diff8;
  logic        start16 = 1'b0, bin16 = 1'b0, busy16, done16, bout16;
  logic [15:0] a16 = '0, b16 = '0, diff16;

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );
  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );
  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
  );

  int total = 0;
  int bad = 0;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // {bout, diff}: signed arithmetic difference, wrapped to w bits, borrow when negative.
  function automatic logic [16:0] ref_model(input int w, input logic [15:0] av,
                                            input logic [15:0] bv, input logic binv);
    int r;
    logic [15:0] mask;
    r = int'(av) - int'(bv) - int'(binv);
    mask = 16'((1 << w) - 1);
    return {(r < 0), 16'(r) & mask};
  endfunction

  task automatic set_inputs(input int w, input logic s, input logic [15:0] av,
                            input logic [15:0] bv, input logic binv);
    case (w)
      1:       begin start1 = s;  a1 = av[0:0];  b1 = bv[0:0];  bin1 = binv;  end
      8:       begin start8 = s;  a8 = av[7:0];  b8 = bv[7:0];  bin8 = binv;  end
      default: begin start16 = s; a16 = av;      b16 = bv;      bin16 = binv; end
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      1:       return done1;
      8:       return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      1:       return busy1;
      8:       return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [16:0] get_result(input int w);
    case (w)
      1:       return {bout1, 15'b0, diff1};
      8:       return {bout8, 8'b0, diff8};
      default: return {bout16, diff16};
    endcase
  endfunction

  // One full operation: launch, count busy cycles, wait (bounded) for done, check.
  task automatic apply_stimulus(input int w, input logic [15:0] av, input logic [15:0] bv,
                                input logic binv, input string tag);
    logic [16:0] exp, got;
    int n, nbusy;
    exp = ref_model(w, av, bv, binv);
    @(negedge clk);
    set_inputs(w, 1'b1, av, bv, binv);
    @(negedge clk);
    set_inputs(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    n = 0;
    nbusy = 0;
    while (!get_done(w) && n < w + 4) begin
      if (get_busy(w)) nbusy++;
      @(negedge clk);
      n++;
    end
    if (!get_done(w)) begin
      check_output({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      got = get_result(w);
      check_output({tag, " diff"}, {16'b0, got[15:0]}, {16'b0, exp[15:0]});
      check_output({tag, " bout"}, {31'b0, got[16]}, {31'b0, exp[16]});
      check_output({tag, " latency"}, n, w);
      check_output({tag, " busy_cycles"}, nbusy, w);
      @(negedge clk);
      check_output({tag, " done_width"}, {31'b0, get_done(w)}, 32'd0);
    end
  endtask

  initial begin
    int pulses, first_pulse, prev_pulse;
    int widths[3] = '{1, 8, 16};
    logic [15:0] ra, rb;

    #12;
    check_output("reset busy8", {31'b0, busy8}, 32'd0);
    check_output("reset done8", {31'b0, done8}, 32'd0);
    check_output("reset diff8", {24'b0, diff8}, 32'd0);
    check_output("reset bout8", {31'b0, bout8}, 32'd0);
    check_output("reset busy16", {31'b0, busy16}, 32'd0);
    check_output("reset done1", {31'b0, done1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(8, 16'h5A, 16'h3C, 1'b0, "5A-3C");
    apply_stimulus(8, 16'h00, 16'h01, 1'b0, "00-01");
    apply_stimulus(8, 16'h10, 16'h10, 1'b1, "10-10-1");
    apply_stimulus(8, 16'hFF, 16'h00, 1'b1, "FF-00-1");

    // A start pulse during RUN must be ignored, leaving one result and one done.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; bin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check_output("ignore busy_at_E3", {31'b0, busy8}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) begin
        pulses++;
        check_output("ignore diff", {24'b0, diff8}, 32'h1E);
        check_output("ignore bout", {31'b0, bout8}, 32'd0);
      end
    end
    check_output("ignore pulses", pulses, 1);

    // Asynchronous reset mid-RUN aborts the operation.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check_output("abort busy_before", {31'b0, busy8}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort busy", {31'b0, busy8}, 32'd0);
    check_output("abort done", {31'b0, done8}, 32'd0);
    check_output("abort diff", {24'b0, diff8}, 32'd0);
    check_output("abort bout", {31'b0, bout8}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    check_output("abort no_done", pulses, 0);
    apply_stimulus(8, 16'hC3, 16'h4D, 1'b1, "after_abort");

    // Continuous start: one done every WIDTH+2 cycles.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0;
    pulses = 0;
    first_pulse = 0;
    prev_pulse = 0;
    for (int i = 1; i <= 60 && pulses < 3; i++) begin
      @(negedge clk);
      if (done8) begin
        check_output("hold diff", {24'b0, diff8}, 32'h1E);
        check_output("hold bout", {31'b0, bout8}, 32'd0);
        if (pulses > 0) check_output("hold period", i - prev_pulse, 10);
        else first_pulse = i;
        prev_pulse = i;
        pulses++;
      end
    end
    start8 = 1'b0;
    check_output("hold pulses", pulses, 3);
    check_output("hold first_latency", first_pulse, 9);
    repeat (3) @(negedge clk);

    // Random regression per width against the arithmetic model.
    foreach (widths[k]) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        if (widths[k] == 1) begin ra = {15'b0, ra[0]}; rb = {15'b0, rb[0]}; end
        if (widths[k] == 8) begin ra = {8'b0, ra[7:0]}; rb = {8'b0, rb[7:0]}; end
        apply_stimulus(widths[k], ra, rb, 1'($urandom), $sformatf("rand_w%0d_%0d", widths[k], i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
